// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared types and constants for the load/store unit.
//                - lsu_state_e : LSU control states
//                - TAG_*       : writeback tag values seen by the reservation
//                                stations
//                - CMD_* / WIDTH_* : request field encodings
//  Revision    : 1.0  initial release
// ============================================================================
package core_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LO       = 3'd1,
        HI       = 3'd2,
        WB       = 3'd3,
        RMW_WAIT = 3'd4,
        RMW_LO   = 3'd5,
        RMW_HI   = 3'd6
    } lsu_state_e;

    localparam logic [1:0] TAG_RSA = 2'b00;
    localparam logic [1:0] TAG_RSB = 2'b01;
    localparam logic [1:0] TAG_RMW = 2'b10;

    localparam logic CMD_LOAD  = 1'b0;
    localparam logic CMD_STORE = 1'b1;

    localparam logic WIDTH_8   = 1'b0;
    localparam logic WIDTH_16  = 1'b1;

    // Station index (0=rsa, 1=rsb) to writeback tag.
    function automatic logic [1:0] station_tag(input logic station);
        return station ? TAG_RSB : TAG_RSA;
    endfunction

endpackage : core_pkg
`default_nettype wire

// File: rtl/lsu_bus_seq.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_bus_seq
//  Description : Byte-cycle sequencer for the 8-bit external bus. Drives the
//                read/write strobe, address and write data from registers and
//                holds them stable until mem_ready_i completes the cycle.
//  Ports       : launch_i      start a byte cycle at launch_adr_i
//                launch_wr_i   1=write cycle, 0=read cycle
//                launch_adr_i  byte address of the new cycle
//                launch_dout_i write data of the new cycle
//                step_i        with done_o: continue with a second byte at
//                              address+1 (wraps), same direction
//                step_dout_i   write data for the stepped byte
//                mem_ready_i   bus cycle completes this clock
//                mem_*_o       bus strobes, address and write data
//                done_o        active cycle completes this clock
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_bus_seq #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              launch_i,
    input  logic              launch_wr_i,
    input  logic [ADDR_W-1:0] launch_adr_i,
    input  logic [7:0]        launch_dout_i,
    input  logic              step_i,
    input  logic [7:0]        step_dout_i,
    input  logic              mem_ready_i,
    output logic              mem_rd_o,
    output logic              mem_wr_o,
    output logic [ADDR_W-1:0] mem_adr_o,
    output logic [7:0]        mem_dout_o,
    output logic              done_o
);

    logic              rd_q;
    logic              wr_q;
    logic [ADDR_W-1:0] adr_q;
    logic [7:0]        dout_q;

    assign done_o     = (rd_q | wr_q) & mem_ready_i;
    assign mem_rd_o   = rd_q;
    assign mem_wr_o   = wr_q;
    assign mem_adr_o  = adr_q;
    assign mem_dout_o = dout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            adr_q  <= '0;
            dout_q <= 8'h00;
        end else if (launch_i) begin
            rd_q   <= ~launch_wr_i;
            wr_q   <= launch_wr_i;
            adr_q  <= launch_adr_i;
            dout_q <= launch_dout_i;
        end else if (done_o) begin
            if (step_i) begin
                // Strobe stays asserted; address wraps naturally at ADDR_W bits.
                adr_q  <= adr_q + ADDR_W'(1);
                dout_q <= step_dout_i;
            end else begin
                rd_q <= 1'b0;
                wr_q <= 1'b0;
            end
        end
    end

endmodule : lsu_bus_seq
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Memory stage. Accepts one load/store/RMW request while idle,
//                runs it as one or two byte cycles (little-endian) on the
//                8-bit bus and returns load data through a tagged one-cycle
//                writeback. lsu_wait stalls the scheduler while busy.
//  Ports       : rq_*/agu_adr/st_data  request (sampled only when idle)
//                rmw_data/rmw_valid    modified value for RMW write-back
//                lsu_wait              busy indication
//                data_out/tag/wb       writeback to reservation stations
//                mem_*                 8-bit external bus
//  Revision    : 1.0  initial release
// ============================================================================
module load_store_unit
    import core_pkg::*;
#(
    parameter int         ADDR_W  = 16,
    parameter logic [1:0] RMW_TAG = TAG_RMW
) (
    input  logic              clk,
    input  logic              a_rst,
    input  logic              rq_start,
    input  logic              rq_cmd,
    input  logic              rq_width,
    input  logic              rq_tag,
    input  logic              rmw_offload,
    input  logic [ADDR_W-1:0] agu_adr,
    input  logic [15:0]       st_data,
    input  logic [15:0]       rmw_data,
    input  logic              rmw_valid,
    output logic              lsu_wait,
    output logic [15:0]       data_out,
    output logic [1:0]        data_tag,
    output logic              data_wb,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [7:0]        mem_dout,
    input  logic [7:0]        mem_din,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_ready
);

    lsu_state_e        state_q, state_d;

    // Request latch
    logic              cmd_q;
    logic              width_q;
    logic              tag_q;
    logic              rmw_q;
    logic [ADDR_W-1:0] adr_q;
    logic [7:0]        st_hi_q;
    logic [7:0]        rmw_hi_q;
    logic [7:0]        lo_q;

    logic              lsu_wait_q;
    logic              data_wb_q;
    logic [15:0]       data_out_q;
    logic [1:0]        data_tag_q;

    // Sequencer controls
    logic              w_launch;
    logic              w_launch_wr;
    logic [ADDR_W-1:0] w_launch_adr;
    logic [7:0]        w_launch_dout;
    logic              w_step;
    logic [7:0]        w_step_dout;
    logic              w_bus_done;

    lsu_bus_seq #(
        .ADDR_W (ADDR_W)
    ) u_bus_seq (
        .clk           (clk),
        .rst           (a_rst),
        .launch_i      (w_launch),
        .launch_wr_i   (w_launch_wr),
        .launch_adr_i  (w_launch_adr),
        .launch_dout_i (w_launch_dout),
        .step_i        (w_step),
        .step_dout_i   (w_step_dout),
        .mem_ready_i   (mem_ready),
        .mem_rd_o      (mem_rd),
        .mem_wr_o      (mem_wr),
        .mem_adr_o     (mem_adr),
        .mem_dout_o    (mem_dout),
        .done_o        (w_bus_done)
    );

    always_comb begin
        state_d       = state_q;
        w_launch      = 1'b0;
        w_launch_wr   = CMD_LOAD;
        w_launch_adr  = adr_q;
        w_launch_dout = 8'h00;
        w_step        = 1'b0;
        w_step_dout   = st_hi_q;

        case (state_q)
            IDLE: begin
                if (rq_start) begin
                    // First byte goes out straight from the request inputs so
                    // the bus cycle starts on the acceptance edge.
                    w_launch      = 1'b1;
                    w_launch_wr   = rq_cmd;
                    w_launch_adr  = agu_adr;
                    w_launch_dout = st_data[7:0];
                    state_d       = LO;
                end
            end
            LO: begin
                if (w_bus_done) begin
                    if (width_q == WIDTH_16) begin
                        w_step  = 1'b1;
                        state_d = HI;
                    end else begin
                        state_d = (cmd_q == CMD_STORE) ? IDLE : WB;
                    end
                end
            end
            HI: begin
                if (w_bus_done) begin
                    state_d = (cmd_q == CMD_STORE) ? IDLE : WB;
                end
            end
            WB: begin
                state_d = rmw_q ? RMW_WAIT : IDLE;
            end
            RMW_WAIT: begin
                if (rmw_valid) begin
                    w_launch      = 1'b1;
                    w_launch_wr   = CMD_STORE;
                    w_launch_adr  = adr_q;
                    w_launch_dout = rmw_data[7:0];
                    state_d       = RMW_LO;
                end
            end
            RMW_LO: begin
                if (w_bus_done) begin
                    if (width_q == WIDTH_16) begin
                        w_step      = 1'b1;
                        w_step_dout = rmw_hi_q;
                        state_d     = RMW_HI;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            RMW_HI: begin
                if (w_bus_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (a_rst) begin
            state_q    <= IDLE;
            cmd_q      <= 1'b0;
            width_q    <= 1'b0;
            tag_q      <= 1'b0;
            rmw_q      <= 1'b0;
            adr_q      <= '0;
            st_hi_q    <= 8'h00;
            rmw_hi_q   <= 8'h00;
            lo_q       <= 8'h00;
            lsu_wait_q <= 1'b0;
            data_wb_q  <= 1'b0;
            data_out_q <= 16'h0000;
            data_tag_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            lsu_wait_q <= (state_d != IDLE);
            // WB is only entered from LO/HI and always left after one cycle.
            data_wb_q  <= (state_d == WB);

            if (state_q == IDLE && rq_start) begin
                cmd_q   <= rq_cmd;
                width_q <= rq_width;
                tag_q   <= rq_tag;
                // A store flagged as RMW behaves as a plain store.
                rmw_q   <= rmw_offload & (rq_cmd == CMD_LOAD);
                adr_q   <= agu_adr;
                st_hi_q <= st_data[15:8];
            end

            if (state_q == LO && w_bus_done) begin
                lo_q <= mem_din;
            end

            if (state_d == WB) begin
                data_out_q <= (state_q == HI) ? {mem_din, lo_q} : {8'h00, mem_din};
                data_tag_q <= rmw_q ? RMW_TAG : station_tag(tag_q);
            end

            if (state_q == RMW_WAIT && rmw_valid) begin
                rmw_hi_q <= rmw_data[15:8];
            end
        end
    end

    assign lsu_wait = lsu_wait_q;
    assign data_wb  = data_wb_q;
    assign data_out = data_out_q;
    assign data_tag = data_tag_q;

endmodule : load_store_unit
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Self-checking bench for load_store_unit. A byte-wide memory
//                with configurable wait states answers the bus; expected bus
//                cycles and writebacks are derived from the request rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        a_rst;
    logic        rq_start, rq_cmd, rq_width, rq_tag, rmw_offload;
    logic [15:0] agu_adr, st_data, rmw_data;
    logic        rmw_valid;
    logic        lsu_wait;
    logic [15:0] data_out;
    logic [1:0]  data_tag;
    logic        data_wb;
    logic [15:0] mem_adr;
    logic [7:0]  mem_dout, mem_din;
    logic        mem_rd, mem_wr, mem_ready;

    always #5 clk = ~clk;

    load_store_unit #(
        .ADDR_W  (16),
        .RMW_TAG (2'b10)
    ) dut (
        .clk         (clk),
        .a_rst       (a_rst),
        .rq_start    (rq_start),
        .rq_cmd      (rq_cmd),
        .rq_width    (rq_width),
        .rq_tag      (rq_tag),
        .rmw_offload (rmw_offload),
        .agu_adr     (agu_adr),
        .st_data     (st_data),
        .rmw_data    (rmw_data),
        .rmw_valid   (rmw_valid),
        .lsu_wait    (lsu_wait),
        .data_out    (data_out),
        .data_tag    (data_tag),
        .data_wb     (data_wb),
        .mem_adr     (mem_adr),
        .mem_dout    (mem_dout),
        .mem_din     (mem_din),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_ready   (mem_ready)
    );

    typedef struct {
        logic [15:0] adr;
        logic        wr;
        logic [7:0]  data;
        int          held;
        time         t;
    } bus_ev_t;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  tag;
    } wb_ev_t;

    logic [7:0] mem [0:65535];
    bus_ev_t    blog[$];
    wb_ev_t     wlog[$];
    int         wait_cfg = -1;
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Bus slave: decides mem_ready on the falling edge, wait count per cycle.
    initial begin : p_slave
        int wleft;
        wleft     = -1;
        mem_ready = 1'b0;
        mem_din   = 8'h00;
        forever begin
            @(negedge clk);
            mem_din = mem[mem_adr];
            if ((mem_rd || mem_wr) && !a_rst) begin
                if (wleft < 0) wleft = (wait_cfg >= 0) ? wait_cfg : int'($urandom_range(0, 3));
                if (wleft == 0) begin
                    mem_ready = 1'b1;
                    wleft     = -1;
                end else begin
                    mem_ready = 1'b0;
                    wleft--;
                end
            end else begin
                mem_ready = 1'b0;
                wleft     = -1;
            end
        end
    end

    // Bus/writeback monitor on the rising edge (pre-update values).
    initial begin : p_mon
        int          held;
        logic        prev_act;
        logic [15:0] prev_adr;
        logic [7:0]  prev_dout;
        logic [1:0]  prev_strb;
        bus_ev_t     ev;
        held = 0; prev_act = 1'b0; prev_adr = '0; prev_dout = '0; prev_strb = '0;
        forever begin
            @(posedge clk);
            if (a_rst) begin
                held = 0; prev_act = 1'b0;
            end else begin
                if (!lsu_wait || data_wb)
                    check("strobe_quiet", 32'({mem_rd, mem_wr}), 32'(0));
                if (mem_rd || mem_wr) begin
                    check("rd_wr_excl", 32'(mem_rd & mem_wr), 32'(0));
                    if (prev_act) begin
                        check("hold_adr",  32'(mem_adr),          32'(prev_adr));
                        check("hold_dout", 32'(mem_dout),         32'(prev_dout));
                        check("hold_strb", 32'({mem_rd, mem_wr}), 32'(prev_strb));
                    end
                    held++;
                    if (mem_ready) begin
                        ev.adr  = mem_adr;
                        ev.wr   = mem_wr;
                        ev.data = mem_wr ? mem_dout : mem_din;
                        ev.held = held;
                        ev.t    = $time;
                        blog.push_back(ev);
                        if (mem_wr) mem[mem_adr] = mem_dout;
                        held = 0; prev_act = 1'b0;
                    end else begin
                        prev_act = 1'b1; prev_adr = mem_adr;
                        prev_dout = mem_dout; prev_strb = {mem_rd, mem_wr};
                    end
                end else begin
                    held = 0; prev_act = 1'b0;
                end
                if (data_wb) wlog.push_back('{d: data_out, tag: data_tag});
            end
        end
    end

    task automatic check_reset_outputs(input string p);
        check({p, "_wait"}, 32'(lsu_wait), 32'(0));
        check({p, "_wb"},   32'(data_wb),  32'(0));
        check({p, "_rd"},   32'(mem_rd),   32'(0));
        check({p, "_wr"},   32'(mem_wr),   32'(0));
        check({p, "_adr"},  32'(mem_adr),  32'(0));
        check({p, "_dout"}, 32'(mem_dout), 32'(0));
        check({p, "_dat"},  32'(data_out), 32'(0));
        check({p, "_tag"},  32'(data_tag), 32'(0));
    endtask

    // One request end to end; expectations follow from the request rules.
    task automatic run_txn(input logic cmd, input logic width, input logic tag,
                           input logic rmw, input logic [15:0] adr,
                           input logic [15:0] st, input logic [15:0] rmwv,
                           input int rmw_delay, input logic hold_start,
                           input int exp_held);
        bus_ev_t     e;
        bus_ev_t     exp_q[$];
        logic [15:0] a;
        logic [15:0] exp_d;
        logic [1:0]  exp_tag;
        logic        is_rmw;
        logic        pulsed;
        int          nb, lim, wcnt;
        time         t_idle;

        is_rmw = rmw & ~cmd;
        nb     = width ? 2 : 1;
        for (int i = 0; i < nb; i++) begin
            a      = adr + 16'(i);
            e.adr  = a;
            e.wr   = cmd;
            e.data = cmd ? ((i == 0) ? st[7:0] : st[15:8]) : mem[a];
            e.held = 0;
            e.t    = 0;
            exp_q.push_back(e);
        end
        exp_d   = width ? {mem[adr + 16'd1], mem[adr]} : {8'h00, mem[adr]};
        exp_tag = is_rmw ? 2'b10 : {1'b0, tag};
        if (is_rmw) begin
            for (int i = 0; i < nb; i++) begin
                e.adr  = adr + 16'(i);
                e.wr   = 1'b1;
                e.data = (i == 0) ? rmwv[7:0] : rmwv[15:8];
                exp_q.push_back(e);
            end
        end

        @(negedge clk);
        lim = 0;
        while (lsu_wait && lim < 500) begin
            @(negedge clk);
            lim++;
        end
        blog.delete();
        wlog.delete();

        rq_start = 1'b1; rq_cmd = cmd; rq_width = width; rq_tag = tag;
        rmw_offload = rmw; agu_adr = adr; st_data = st;
        rmw_valid = 1'b0; rmw_data = 16'($urandom);
        @(negedge clk);
        // Scramble request inputs after acceptance; a stray rmw_valid while
        // the bus cycle runs must be ignored.
        rq_start = hold_start;
        rq_cmd = 1'($urandom); rq_width = 1'($urandom); rq_tag = 1'($urandom);
        rmw_offload = 1'($urandom); agu_adr = 16'($urandom); st_data = 16'($urandom);
        rmw_valid = 1'b1; rmw_data = 16'($urandom);

        lim = 0; wcnt = 0; pulsed = 1'b0;
        do begin
            @(negedge clk);
            lim++;
            rmw_valid = 1'b0;
            rmw_data  = 16'($urandom);
            if (is_rmw && !pulsed && wlog.size() > 0) begin
                if (wcnt == rmw_delay) begin
                    rmw_valid = 1'b1;
                    rmw_data  = rmwv;
                    pulsed    = 1'b1;
                end
                wcnt++;
            end
        end while ((lsu_wait || rmw_valid) && lim < 500);
        rq_start  = 1'b0;
        rmw_valid = 1'b0;
        t_idle    = $time;

        check("idle_reached", 32'(lsu_wait), 32'(0));
        check("n_bus", 32'(blog.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < blog.size(); i++) begin
            check("bus_adr",  32'(blog[i].adr),  32'(exp_q[i].adr));
            check("bus_wr",   32'(blog[i].wr),   32'(exp_q[i].wr));
            check("bus_data", 32'(blog[i].data), 32'(exp_q[i].data));
        end
        check("n_wb", 32'(wlog.size()), 32'(cmd ? 0 : 1));
        if (!cmd && wlog.size() > 0) begin
            check("wb_data", 32'(wlog[0].d),   32'(exp_d));
            check("wb_tag",  32'(wlog[0].tag), 32'(exp_tag));
        end
        if (blog.size() > 0)
            check("idle_latency", 32'(t_idle - blog[blog.size()-1].t),
                  32'((cmd || is_rmw) ? 5 : 15));
        if (exp_held > 0 && blog.size() > 0)
            check("strobe_held", 32'(blog[0].held), 32'(exp_held));
    endtask

    initial begin : p_main
        logic [15:0] ra;
        int          lim;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        a_rst = 1'b1; rq_start = 1'b0; rq_cmd = 1'b0; rq_width = 1'b0; rq_tag = 1'b0;
        rmw_offload = 1'b0; agu_adr = '0; st_data = '0; rmw_data = '0; rmw_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        a_rst = 1'b0;

        // Byte load with two wait states.
        mem[16'h0200] = 8'hA5;
        wait_cfg = 2;
        run_txn(1'b0, 1'b0, 1'b1, 1'b0, 16'h0200, 16'($urandom), 16'($urandom), 0, 1'b0, 3);
        if (wlog.size() > 0) begin
            check("t1_data", 32'(wlog[0].d),   32'h00A5);
            check("t1_tag",  32'(wlog[0].tag), 32'(2'b01));
        end

        // Word load across the address wrap.
        wait_cfg = -1;
        mem[16'hFFFF] = 8'h34;
        mem[16'h0000] = 8'h12;
        run_txn(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'($urandom), 16'($urandom), 0, 1'b0, 0);
        if (wlog.size() > 0) check("t2_data", 32'(wlog[0].d), 32'h1234);

        // Word store.
        run_txn(1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 16'($urandom), 0, 1'b0, 0);
        check("t3_mem_lo", 32'(mem[16'h0010]), 32'hEF);
        check("t3_mem_hi", 32'(mem[16'h0011]), 32'hBE);

        // rq_start held high for the whole transaction.
        run_txn(1'b0, 1'b0, 1'b0, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 0, 1'b1, 0);

        // Byte RMW, modified value returned four cycles after the read.
        mem[16'h0040] = 8'h7F;
        run_txn(1'b0, 1'b0, 1'b1, 1'b1, 16'h0040, 16'($urandom), 16'h0080, 4, 1'b0, 0);
        if (wlog.size() > 0) begin
            check("t5_data", 32'(wlog[0].d),   32'h007F);
            check("t5_tag",  32'(wlog[0].tag), 32'(2'b10));
        end
        check("t5_mem", 32'(mem[16'h0040]), 32'h80);

        // Store with rmw_offload set behaves as a plain store.
        run_txn(1'b1, 1'b0, 1'b0, 1'b1, 16'h0123, 16'h5A5A, 16'($urandom), 0, 1'b0, 0);

        // Reset during the high byte of a word load.
        wait_cfg = 2;
        ra = 16'h1230;
        @(negedge clk);
        blog.delete(); wlog.delete();
        rq_start = 1'b1; rq_cmd = 1'b0; rq_width = 1'b1; rq_tag = 1'b1;
        rmw_offload = 1'b0; agu_adr = ra; st_data = '0;
        @(negedge clk);
        rq_start = 1'b0;
        lim = 0;
        while (blog.size() == 0 && lim < 100) begin
            @(negedge clk);
            lim++;
        end
        check("t6_in_hi", 32'(mem_adr), 32'(ra + 16'd1));
        a_rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("t6_abort");
        @(negedge clk);
        a_rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_no_wb", 32'(wlog.size()), 32'(0));
        check("t6_no_strobe", 32'({mem_rd, mem_wr}), 32'(0));
        wait_cfg = -1;
        run_txn(1'b0, 1'b0, 1'b0, 1'b0, 16'h0321, 16'($urandom), 16'($urandom), 0, 1'b0, 0);

        // Randomized requests.
        for (int n = 0; n < 40; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            run_txn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), ra,
                    16'($urandom), 16'($urandom), int'($urandom_range(0, 5)), 1'b0, 0);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_load_store_unit
`default_nettype wire
